// File: rtl/jfpjc_dct_dispatcher.sv
// ---------------------------------------------------------------------------
// jfpjc_dct_dispatcher
//
// Schedules a bank of NUM_DCTS DCT engines over the completed half of the
// hm01b0 ingester double buffer. A toggle on frontbuffer_select marks a new
// buffer as ready; the completed bank is latched as dct_read_bank and the
// engines are stepped through MCU_GROUPS groups. Each group starts with
// dct_nreset held low for RESET_CYCLES cycles and ends once every engine has
// reported finished. A swap arriving before the buffer is fully processed
// raises a sticky overrun_err and restarts on the new buffer.
//
// Ports
//   clock               in   system clock, posedge
//   nreset              in   asynchronous active-low reset
//   frontbuffer_select  in   ingester front bank; each toggle = new buffer
//   dcts_finished       in   per-engine finished flags (level or pulse)
//   err_clear           in   clears overrun_err
//   dct_nreset          out  active-low reset shared by all engines
//   dct_read_bank       out  bank the engines read from
//   mcu_group           out  current group (upper fetch-address bits)
//   dcts_outbuf         out  DCT result-buffer index, wraps
//   busy                out  high while in RESET or ACTIVE
//   frame_done          out  1-cycle pulse after the last group completes
//   overrun_err         out  sticky overrun flag
//   frame_count         out  (DCT_DISPATCH_STATS_EN) frames completed, wraps
//   overrun_count       out  (DCT_DISPATCH_STATS_EN) overruns, saturates
//
// Optional feature macro: DCT_DISPATCH_STATS_EN
// ---------------------------------------------------------------------------
module jfpjc_dct_dispatcher #(
  parameter int unsigned NUM_DCTS     = 5,
  parameter int unsigned MCU_GROUPS   = 8,
  parameter int unsigned GROUP_W      = 3,
  parameter int unsigned RESET_CYCLES = 3,
  parameter int unsigned OUT_BUF_BITS = 2
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    frontbuffer_select,
  input  logic [NUM_DCTS-1:0]     dcts_finished,
  input  logic                    err_clear,
  output logic                    dct_nreset,
  output logic                    dct_read_bank,
  output logic [GROUP_W-1:0]      mcu_group,
  output logic [OUT_BUF_BITS-1:0] dcts_outbuf,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun_err
`ifdef DCT_DISPATCH_STATS_EN
  ,
  output logic [15:0]             frame_count,
  output logic [7:0]              overrun_count
`endif
);

  localparam int unsigned RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0]    RC_LAST  = RC_W'(RESET_CYCLES - 1);
  localparam logic [GROUP_W-1:0] GRP_LAST = GROUP_W'(MCU_GROUPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_ACTIVE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic                    r_fb_d0;
  logic                    r_fb_d1;
  logic                    r_read_bank;
  logic [GROUP_W-1:0]      r_mcu_group;
  logic [OUT_BUF_BITS-1:0] r_outbuf;
  logic [NUM_DCTS-1:0]     r_done_mask;
  logic [RC_W-1:0]         r_rst_cnt;
  logic                    r_frame_done;
  logic                    r_overrun_err;

  logic                    w_swap;
  logic                    w_all_done;
  logic                    w_last;
  logic                    w_final_done;
  logic                    w_overrun;

  assign w_swap       = r_fb_d0 != r_fb_d1;
  // Include this cycle's flags so a pulse on the completing cycle counts.
  assign w_all_done   = (r_state == S_ACTIVE) &&
                        ((r_done_mask | dcts_finished) == {NUM_DCTS{1'b1}});
  assign w_last       = r_mcu_group == GRP_LAST;
  assign w_final_done = w_all_done && w_last;
  // A swap colliding with the final completion is a clean hand-over.
  assign w_overrun    = w_swap && ((r_state == S_RESET) ||
                                   ((r_state == S_ACTIVE) && !w_final_done));

  // State register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic: an accepted swap always restarts in RESET
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_swap) w_state_nxt = S_RESET;
      end
      S_RESET: begin
        if (w_swap)                     w_state_nxt = S_RESET;
        else if (r_rst_cnt == RC_LAST)  w_state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (w_swap)          w_state_nxt = S_RESET;
        else if (w_all_done) w_state_nxt = w_last ? S_IDLE : S_RESET;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    dct_nreset = (r_state == S_ACTIVE);
    busy       = (r_state != S_IDLE);
  end

  // Datapath
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_fb_d0       <= 1'b0;
      r_fb_d1       <= 1'b0;
      r_read_bank   <= 1'b0;
      r_mcu_group   <= '0;
      r_outbuf      <= '0;
      r_done_mask   <= '0;
      r_rst_cnt     <= '0;
      r_frame_done  <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_fb_d0      <= frontbuffer_select;
      r_fb_d1      <= r_fb_d0;
      r_frame_done <= w_final_done;

      if (w_overrun)      r_overrun_err <= 1'b1;
      else if (err_clear) r_overrun_err <= 1'b0;

      if (w_all_done) r_outbuf <= r_outbuf + 1'b1;

      if (w_swap) begin
        r_read_bank <= r_fb_d1;
        r_mcu_group <= '0;
        r_done_mask <= '0;
        r_rst_cnt   <= '0;
      end else begin
        case (r_state)
          S_RESET: begin
            // Cleared on the exit cycle so the next group counts from zero.
            r_rst_cnt <= (r_rst_cnt == RC_LAST) ? '0 : r_rst_cnt + 1'b1;
          end
          S_ACTIVE: begin
            if (w_all_done) begin
              r_done_mask <= '0;
              r_mcu_group <= w_last ? '0 : r_mcu_group + 1'b1;
            end else begin
              r_done_mask <= r_done_mask | dcts_finished;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dct_read_bank = r_read_bank;
  assign mcu_group     = r_mcu_group;
  assign dcts_outbuf   = r_outbuf;
  assign frame_done    = r_frame_done;
  assign overrun_err   = r_overrun_err;

`ifdef DCT_DISPATCH_STATS_EN
  logic [15:0] r_frame_count;
  logic [7:0]  r_overrun_count;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_frame_count   <= '0;
      r_overrun_count <= '0;
    end else begin
      if (w_final_done) r_frame_count <= r_frame_count + 1'b1;
      if (w_overrun && (r_overrun_count != 8'hFF))
        r_overrun_count <= r_overrun_count + 1'b1;
    end
  end

  assign frame_count   = r_frame_count;
  assign overrun_count = r_overrun_count;
`endif

endmodule

// File: tb/tb_jfpjc_dct_dispatcher.sv
module tb_jfpjc_dct_dispatcher;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       nreset;
  logic       fbs;
  logic [4:0] fin;
  logic       err_clear;
  logic       dct_nreset, dct_read_bank, busy, frame_done, overrun_err;
  logic [2:0] mcu_group;
  logic [1:0] dcts_outbuf;

  logic       s_fbs;
  logic [2:0] s_fin;
  logic       s_clr;
  logic       s_dct_nreset, s_bank, s_busy, s_fd, s_oe;
  logic [1:0] s_grp;
  logic [1:0] s_ob;
`ifdef DCT_DISPATCH_STATS_EN
  logic [15:0] fc, s_fc;
  logic [7:0]  oc, s_oc;
`endif

  jfpjc_dct_dispatcher u_dut (
    .clock(clock), .nreset(nreset), .frontbuffer_select(fbs),
    .dcts_finished(fin), .err_clear(err_clear),
    .dct_nreset(dct_nreset), .dct_read_bank(dct_read_bank),
    .mcu_group(mcu_group), .dcts_outbuf(dcts_outbuf), .busy(busy),
    .frame_done(frame_done), .overrun_err(overrun_err)
`ifdef DCT_DISPATCH_STATS_EN
    , .frame_count(fc), .overrun_count(oc)
`endif
  );

  jfpjc_dct_dispatcher #(
    .NUM_DCTS(3), .MCU_GROUPS(4), .GROUP_W(2), .RESET_CYCLES(1), .OUT_BUF_BITS(2)
  ) u_small (
    .clock(clock), .nreset(nreset), .frontbuffer_select(s_fbs),
    .dcts_finished(s_fin), .err_clear(s_clr),
    .dct_nreset(s_dct_nreset), .dct_read_bank(s_bank),
    .mcu_group(s_grp), .dcts_outbuf(s_ob), .busy(s_busy),
    .frame_done(s_fd), .overrun_err(s_oe)
`ifdef DCT_DISPATCH_STATS_EN
    , .frame_count(s_fc), .overrun_count(s_oc)
`endif
  );

  int errors = 0;
  int checks = 0;
  int exp_ob = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Counts cycles with busy high and dct_nreset low until the group is active.
  task automatic wait_active(output int lowc);
    int n;
    lowc = 0;
    n = 0;
    while (dct_nreset !== 1'b1 && n < 100) begin
      if (busy === 1'b1) lowc++;
      tick;
      n++;
    end
    chk("wait_active", dct_nreset, 1);
  endtask

  task automatic grp(input int eg, input logic eb, input int delay);
    int lowc;
    wait_active(lowc);
    chk("grp_low_cycles", lowc, 3);
    chk("grp_index", mcu_group, eg);
    chk("grp_bank", dct_read_bank, eb);
    repeat (delay) tick;
    chk("grp_still_active", dct_nreset, 1);
    fin = '1;
    tick;
    fin = '0;
    exp_ob++;
    chk("outbuf", dcts_outbuf, exp_ob % 4);
    if (eg == 7) begin
      chk("frame_done_last", frame_done, 1);
      chk("idle_after_frame", busy, 0);
      chk("grp_wrap", mcu_group, 0);
    end else begin
      chk("no_frame_done", frame_done, 0);
      chk("next_grp", mcu_group, eg + 1);
      chk("next_reset_low", dct_nreset, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lowc;
    int n;
    nreset = 1'b0; fbs = 1'b0; fin = '0; err_clear = 1'b0;
    s_fbs = 1'b0; s_fin = '0; s_clr = 1'b0;

    // Reset values
    #1;
    chk("rst_dct_nreset", dct_nreset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grp", mcu_group, 0);
    chk("rst_outbuf", dcts_outbuf, 0);
    chk("rst_bank", dct_read_bank, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun_err, 0);
    #20 nreset = 1'b1;
    repeat (3) tick;
    chk("idle_no_swap", busy, 0);

    // Test 1: full frame, bank 0 completed when front goes 0->1
    fbs = 1'b1;
    for (int g = 0; g < 8; g++) grp(g, 1'b0, 20);
    tick;
    chk("frame_done_pulse_end", frame_done, 0);
    chk("t1_outbuf_wrapped", dcts_outbuf, 0);
    chk("t1_no_overrun", overrun_err, 0);

    // Test 2: staggered 1-cycle finishes, front 1->0 so bank 1 is read
    fbs = 1'b0;
    wait_active(lowc);
    chk("t2_low_cycles", lowc, 3);
    chk("t2_bank", dct_read_bank, 1);
    repeat (10) tick;
    for (int i = 0; i < 5; i++) begin
      fin = 5'(1 << i);
      tick;
      fin = '0;
      if (i < 4) begin
        chk("stagger_hold_active", dct_nreset, 1);
        chk("stagger_hold_grp", mcu_group, 0);
      end
    end
    exp_ob++;
    chk("stagger_advance_grp", mcu_group, 1);
    chk("stagger_advance_reset", dct_nreset, 0);
    chk("stagger_outbuf", dcts_outbuf, exp_ob % 4);
    grp(1, 1'b1, 15);
    grp(2, 1'b1, 15);

    // Test 3: overrun during group 3, front 0->1 so bank 0 restarts
    wait_active(lowc);
    chk("t3_grp3", mcu_group, 3);
    repeat (5) tick;
    fbs = 1'b1;
    tick;
    chk("t3_overrun_not_yet", overrun_err, 0);
    tick;
    chk("t3_overrun_set", overrun_err, 1);
    chk("t3_grp_restart", mcu_group, 0);
    chk("t3_bank", dct_read_bank, 0);
    chk("t3_reset_low", dct_nreset, 0);
    chk("t3_busy", busy, 1);
    chk("t3_outbuf_kept", dcts_outbuf, exp_ob % 4);
    for (int g = 0; g < 8; g++) grp(g, 1'b0, 20);
    chk("t3_overrun_sticky", overrun_err, 1);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    chk("t3_err_cleared", overrun_err, 0);
    chk("t3_frame_done_gone", frame_done, 0);

    // Test 4: swap lands on the group-7 completion edge
    fbs = 1'b0;
    for (int g = 0; g < 7; g++) grp(g, 1'b1, 12);
    wait_active(lowc);
    chk("t4_grp7", mcu_group, 7);
    repeat (4) tick;
    fbs = 1'b1;
    tick;
    fin = '1;
    tick;
    fin = '0;
    exp_ob++;
    chk("t4_frame_done", frame_done, 1);
    chk("t4_no_overrun", overrun_err, 0);
    chk("t4_new_reset_busy", busy, 1);
    chk("t4_new_reset_low", dct_nreset, 0);
    chk("t4_grp0", mcu_group, 0);
    chk("t4_bank", dct_read_bank, 0);
    chk("t4_outbuf", dcts_outbuf, exp_ob % 4);
    // err_clear on the same edge as a new overrun: overrun wins
    fbs = 1'b0;
    tick;
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    chk("t4_clear_vs_overrun", overrun_err, 1);
    chk("t4_bank_after_overrun", dct_read_bank, 1);

    // Test 5: asynchronous reset mid-ACTIVE
    grp(0, 1'b1, 8);
    wait_active(lowc);
    chk("t5_grp1", mcu_group, 1);
    repeat (3) tick;
    #2 nreset = 1'b0;
    #1;
    chk("t5_dct_nreset", dct_nreset, 0);
    chk("t5_busy", busy, 0);
    chk("t5_grp", mcu_group, 0);
    chk("t5_outbuf", dcts_outbuf, 0);
    chk("t5_bank", dct_read_bank, 0);
    chk("t5_overrun", overrun_err, 0);
    chk("t5_frame_done", frame_done, 0);
    exp_ob = 0;
    repeat (2) tick;
    #3 nreset = 1'b1;
    repeat (10) tick;
    chk("t5_idle_after_release", busy, 0);
    fbs = 1'b1;
    tick;
    tick;
    chk("t5_restart_busy", busy, 1);
    chk("t5_restart_bank", dct_read_bank, 0);

    // Test 6: small instance, 3 engines, 4 groups, 1 reset cycle
    for (int f = 0; f < 3; f++) begin
      s_fbs = ~s_fbs;
      for (int g = 0; g < 4; g++) begin
        lowc = 0;
        n = 0;
        while (s_dct_nreset !== 1'b1 && n < 100) begin
          if (s_busy === 1'b1) lowc++;
          tick;
          n++;
        end
        chk("s_wait_active", s_dct_nreset, 1);
        chk("s_low_cycles", lowc, 1);
        chk("s_grp", s_grp, g);
        chk("s_bank", s_bank, f % 2);
        repeat (3) tick;
        s_fin = '1;
        tick;
        s_fin = '0;
        chk("s_frame_done", s_fd, (g == 3) ? 1 : 0);
      end
    end
`ifdef DCT_DISPATCH_STATS_EN
    chk("s_frame_count", s_fc, 3);
`endif
    // 301 back-to-back toggles: first swap from IDLE, then 300 overruns
    for (int k = 0; k < 301; k++) begin
      s_fbs = ~s_fbs;
      tick;
    end
    repeat (3) tick;
    chk("s_overrun_err", s_oe, 1);
`ifdef DCT_DISPATCH_STATS_EN
    chk("s_overrun_count_sat", s_oc, 8'hFF);
    chk("s_frame_count_kept", s_fc, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
